// File: rtl/digital_clock.sv
// 24-hour clock with alarm, stopwatch and countdown timer on a 1 kHz clock.
// Drives a multiplexed 8-digit 7-segment display, a piezo and status LEDs.
module digital_clock #(
    parameter int CLK_HZ   = 1000,
    parameter int CS_DIV   = 10,
    parameter int RING_SEC = 10
) (
    input  logic       clk_1k,
    input  logic       clr_sw,
    input  logic       alarm_sw,
    input  logic       stopwatch_sw,
    input  logic       timer_sw,
    input  logic [8:0] btn,
    output logic [7:0] seg_data,
    output logic [7:0] seg_sel,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       piezo,
    output logic [7:0] led_1,
    output logic [3:0] led_r,
    output logic [3:0] led_g,
    output logic [3:0] led_b
);

    localparam int PRE_W  = $clog2(CLK_HZ + 1);
    localparam int CS_W   = $clog2(CS_DIV + 1);
    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam logic [3:0] DASH  = 4'hA;
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_SW    = 2'd2,
        MODE_TIMER = 2'd3
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [8:0]        btn_d_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d, sec_q, sec_d;
    logic [4:0]        al_hour_q, al_hour_d;
    logic [5:0]        al_min_q, al_min_d;
    logic              al_en_q, al_en_d;
    logic [CS_W-1:0]   cs_pre_q, cs_pre_d;
    logic [6:0]        sw_cs_q, sw_cs_d;
    logic [5:0]        sw_sec_q, sw_sec_d, sw_min_q, sw_min_d;
    logic              sw_run_q, sw_run_d;
    logic [5:0]        tm_min_q, tm_min_d, tm_sec_q, tm_sec_d;
    logic              tm_run_q, tm_run_d;
    logic              ring_q, ring_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              piezo_q, piezo_d;
    logic [2:0]        scan_q;

    logic [8:0] press;
    logic       any_press;
    logic [3:0] act;
    logic       sec_tick, cs_tick, alarm_hit, tm_expire;

    assign press     = btn & ~btn_d_q;
    assign any_press = |press;
    // Only the lowest-index press acts, and nothing acts while ringing.
    assign act[0] = ~ring_q & press[0];
    assign act[1] = ~ring_q & press[1] & ~press[0];
    assign act[2] = ~ring_q & press[2] & ~|press[1:0];
    assign act[3] = ~ring_q & press[3] & ~|press[2:0];

    assign sec_tick = (pre_q == PRE_W'(CLK_HZ - 1));
    assign cs_tick  = sw_run_q && (cs_pre_q == CS_W'(CS_DIV - 1));

    always_comb begin
        if (timer_sw)          mode_d = MODE_TIMER;
        else if (stopwatch_sw) mode_d = MODE_SW;
        else if (alarm_sw)     mode_d = MODE_ALARM;
        else                   mode_d = MODE_CLOCK;
    end

    always_comb begin
        pre_d      = sec_tick ? '0 : pre_q + PRE_W'(1);
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        al_en_d    = al_en_q;
        cs_pre_d   = (sw_run_q && !cs_tick) ? cs_pre_q + CS_W'(1) : '0;
        sw_cs_d    = sw_cs_q;
        sw_sec_d   = sw_sec_q;
        sw_min_d   = sw_min_q;
        sw_run_d   = sw_run_q;
        tm_min_d   = tm_min_q;
        tm_sec_d   = tm_sec_q;
        tm_run_d   = tm_run_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        tm_expire  = 1'b0;

        if (sec_tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        // Alarm compares against the ticked time, before any button edits.
        alarm_hit = sec_tick && al_en_q && (hour_d == al_hour_q) &&
                    (min_d == al_min_q) && (sec_d == 6'd0);

        if (cs_tick) begin
            if (sw_cs_q == 7'd99) begin
                sw_cs_d = 7'd0;
                if (sw_sec_q == 6'd59) begin
                    sw_sec_d = 6'd0;
                    sw_min_d = (sw_min_q == 6'd59) ? 6'd0 : sw_min_q + 6'd1;
                end else begin
                    sw_sec_d = sw_sec_q + 6'd1;
                end
            end else begin
                sw_cs_d = sw_cs_q + 7'd1;
            end
        end

        if (tm_run_q && sec_tick) begin
            if (tm_sec_q == 6'd0) begin
                tm_sec_d = 6'd59;
                tm_min_d = tm_min_q - 6'd1;
            end else begin
                tm_sec_d = tm_sec_q - 6'd1;
            end
            if (tm_min_q == 6'd0 && tm_sec_q == 6'd1) begin
                tm_run_d  = 1'b0;
                tm_expire = 1'b1;
            end
        end

        case (mode_q)
            MODE_CLOCK: begin
                if (act[0]) hour_d = (hour_d == 5'd23) ? 5'd0 : hour_d + 5'd1;
                if (act[1]) min_d = (min_d == 6'd59) ? 6'd0 : min_d + 6'd1;
                if (act[2]) begin
                    sec_d = 6'd0;
                    pre_d = '0;
                end
            end
            MODE_ALARM: begin
                if (act[0]) al_hour_d = (al_hour_q == 5'd23) ? 5'd0 : al_hour_q + 5'd1;
                if (act[1]) al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
                if (act[2]) al_en_d = ~al_en_q;
            end
            MODE_SW: begin
                if (act[0]) sw_run_d = ~sw_run_q;
                if (act[1] && !sw_run_q) begin
                    sw_cs_d  = 7'd0;
                    sw_sec_d = 6'd0;
                    sw_min_d = 6'd0;
                end
            end
            MODE_TIMER: begin
                if (act[0]) begin
                    if (tm_run_q) tm_run_d = 1'b0;
                    else if (tm_min_q != 6'd0 || tm_sec_q != 6'd0) tm_run_d = 1'b1;
                end
                if (!tm_run_q) begin
                    if (act[1]) tm_min_d = (tm_min_q == 6'd59) ? 6'd0 : tm_min_q + 6'd1;
                    if (act[2]) tm_sec_d = (tm_sec_q == 6'd59) ? 6'd0 : tm_sec_q + 6'd1;
                    if (act[3]) begin
                        tm_min_d = 6'd0;
                        tm_sec_d = 6'd0;
                    end
                end
            end
            default: ;
        endcase

        // A new ring event wins over a stop in the same cycle.
        if (ring_q && sec_tick) begin
            if (ring_cnt_q == RING_W'(RING_SEC - 1)) ring_d = 1'b0;
            else ring_cnt_d = ring_cnt_q + RING_W'(1);
        end
        if (ring_q && any_press) ring_d = 1'b0;
        if (alarm_hit || tm_expire) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end
        piezo_d = ring_d & ~piezo_q;
    end

    always_ff @(posedge clk_1k) begin
        if (clr_sw) begin
            mode_q     <= MODE_CLOCK;
            btn_d_q    <= '0;
            pre_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            al_hour_q  <= '0;
            al_min_q   <= '0;
            al_en_q    <= 1'b0;
            cs_pre_q   <= '0;
            sw_cs_q    <= '0;
            sw_sec_q   <= '0;
            sw_min_q   <= '0;
            sw_run_q   <= 1'b0;
            tm_min_q   <= '0;
            tm_sec_q   <= '0;
            tm_run_q   <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
            piezo_q    <= 1'b0;
            scan_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            btn_d_q    <= btn;
            pre_q      <= pre_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            al_en_q    <= al_en_d;
            cs_pre_q   <= cs_pre_d;
            sw_cs_q    <= sw_cs_d;
            sw_sec_q   <= sw_sec_d;
            sw_min_q   <= sw_min_d;
            sw_run_q   <= sw_run_d;
            tm_min_q   <= tm_min_d;
            tm_sec_q   <= tm_sec_d;
            tm_run_q   <= tm_run_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            piezo_q    <= piezo_d;
            scan_q     <= scan_q + 3'd1;
        end
    end

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            DASH: return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0][3:0] digs;

    always_comb begin
        case (mode_q)
            MODE_CLOCK: digs = {tens_of(7'(hour_q)), ones_of(7'(hour_q)), DASH,
                                tens_of(7'(min_q)), ones_of(7'(min_q)), DASH,
                                tens_of(7'(sec_q)), ones_of(7'(sec_q))};
            MODE_ALARM: digs = {tens_of(7'(al_hour_q)), ones_of(7'(al_hour_q)), DASH,
                                tens_of(7'(al_min_q)), ones_of(7'(al_min_q)), DASH,
                                BLANK, {3'b000, al_en_q}};
            MODE_SW:    digs = {tens_of(7'(sw_min_q)), ones_of(7'(sw_min_q)), DASH,
                                tens_of(7'(sw_sec_q)), ones_of(7'(sw_sec_q)), DASH,
                                tens_of(sw_cs_q), ones_of(sw_cs_q)};
            MODE_TIMER: digs = {BLANK, BLANK, DASH,
                                tens_of(7'(tm_min_q)), ones_of(7'(tm_min_q)), DASH,
                                tens_of(7'(tm_sec_q)), ones_of(7'(tm_sec_q))};
            default:    digs = {8{BLANK}};
        endcase
    end

    assign seg_data = seg_code(digs[scan_q]);
    assign seg_sel  = ~(8'd1 << scan_q);
    assign piezo    = piezo_q;
    assign led_1    = {ring_q, tm_run_q, sw_run_q, al_en_q, 4'(4'b0001 << mode_q)};
    assign led_r    = {4{ring_q}};
    assign led_g    = {4{sw_run_q | tm_run_q}};
    assign led_b    = {4{al_en_q}};
    assign lcd_rs   = 1'b0;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = 1'b0;
    assign lcd_data = 8'h00;

endmodule

// File: tb/tb_digital_clock.sv
// Bench for digital_clock: directed scenarios plus random buttons/switches,
// every cycle checked against a seconds/centiseconds-level reference model.
module tb_digital_clock;

    localparam int CLK_HZ   = 1000;
    localparam int CS_DIV   = 10;
    localparam int RING_SEC = 10;

    logic       clk_1k = 1'b0;
    logic       clr_sw, alarm_sw, stopwatch_sw, timer_sw;
    logic [8:0] btn;
    logic [7:0] seg_data, seg_sel, lcd_data, led_1;
    logic       lcd_rs, lcd_rw, lcd_e, piezo;
    logic [3:0] led_r, led_g, led_b;

    always #5 clk_1k = ~clk_1k;

    digital_clock #(.CLK_HZ(CLK_HZ), .CS_DIV(CS_DIV), .RING_SEC(RING_SEC)) dut (
        .clk_1k(clk_1k), .clr_sw(clr_sw), .alarm_sw(alarm_sw),
        .stopwatch_sw(stopwatch_sw), .timer_sw(timer_sw), .btn(btn),
        .seg_data(seg_data), .seg_sel(seg_sel), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .piezo(piezo), .led_1(led_1),
        .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // Reference model: time of day in seconds, stopwatch in centiseconds,
    // timer in seconds, ring as a count of remaining second ticks.
    int         m_pre, m_time, m_al_h, m_al_m, m_sw, m_sw_pre, m_tm, m_ring_left;
    int         m_scan, m_mode;
    bit         m_al_en, m_sw_run, m_tm_run, m_ring, m_piezo;
    logic [8:0] m_btn_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_time = 0; m_al_h = 0; m_al_m = 0; m_al_en = 0;
        m_sw = 0; m_sw_pre = 0; m_sw_run = 0; m_tm = 0; m_tm_run = 0;
        m_ring = 0; m_ring_left = 0; m_piezo = 0; m_scan = 0; m_mode = 0;
        m_btn_prev = '0;
    endtask

    task automatic model_step();
        logic [8:0] pr;
        int  k, a, h, mi, s, tm_old;
        bit  tick, cs_tick, hit, expire, tm_was, ring_was;
        if (clr_sw) begin
            model_reset();
            return;
        end
        tick  = (m_pre == CLK_HZ - 1);
        m_pre = tick ? 0 : m_pre + 1;
        pr = btn & ~m_btn_prev;
        m_btn_prev = btn;
        k = -1;
        for (int i = 8; i >= 0; i--) if (pr[i]) k = i;
        ring_was = m_ring;
        a = ring_was ? -1 : k;

        if (tick) m_time = (m_time + 1) % 86400;
        hit = tick && m_al_en && (m_time == m_al_h * 3600 + m_al_m * 60);

        cs_tick  = m_sw_run && (m_sw_pre == CS_DIV - 1);
        m_sw_pre = (m_sw_run && !cs_tick) ? m_sw_pre + 1 : 0;
        if (cs_tick) m_sw = (m_sw + 1) % 360000;

        tm_was = m_tm_run; tm_old = m_tm; expire = 0;
        if (m_tm_run && tick) begin
            m_tm--;
            if (m_tm == 0) begin m_tm_run = 0; expire = 1; end
        end

        case (m_mode)
            0: begin
                h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
                if (a == 0) h = (h + 1) % 24;
                if (a == 1) mi = (mi + 1) % 60;
                if (a == 2) begin s = 0; m_pre = 0; end
                m_time = h * 3600 + mi * 60 + s;
            end
            1: begin
                if (a == 0) m_al_h = (m_al_h + 1) % 24;
                if (a == 1) m_al_m = (m_al_m + 1) % 60;
                if (a == 2) m_al_en = !m_al_en;
            end
            2: begin
                if (a == 0) m_sw_run = !m_sw_run;
                else if (a == 1 && !m_sw_run) m_sw = 0;
            end
            default: begin
                if (a == 0) begin
                    if (tm_was) m_tm_run = 0;
                    else if (tm_old != 0) m_tm_run = 1;
                end
                if (!tm_was) begin
                    if (a == 1) m_tm = ((m_tm / 60 + 1) % 60) * 60 + m_tm % 60;
                    if (a == 2) m_tm = (m_tm / 60) * 60 + (m_tm % 60 + 1) % 60;
                    if (a == 3) m_tm = 0;
                end
            end
        endcase

        if (ring_was && tick) begin
            m_ring_left--;
            if (m_ring_left == 0) m_ring = 0;
        end
        if (ring_was && k >= 0) m_ring = 0;
        if (hit || expire) begin m_ring = 1; m_ring_left = RING_SEC; end
        m_piezo = m_ring ? !m_piezo : 1'b0;
        m_scan  = (m_scan + 1) % 8;
        m_mode  = timer_sw ? 3 : stopwatch_sw ? 2 : alarm_sw ? 1 : 0;
    endtask

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
            8: return 8'h7F; 9: return 8'h6F; 10: return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    // Digit value for display position idx (10 = dash, 11 = blank).
    function automatic int model_digit(input int idx);
        int dv[8];
        int x, y, z;
        case (m_mode)
            0: begin x = m_time / 3600; y = (m_time / 60) % 60; z = m_time % 60; end
            1: begin x = m_al_h; y = m_al_m; z = 0; end
            2: begin x = m_sw / 6000; y = (m_sw / 100) % 60; z = m_sw % 100; end
            default: begin x = 0; y = m_tm / 60; z = m_tm % 60; end
        endcase
        if (m_mode == 1) begin
            dv = '{m_al_en ? 1 : 0, 11, 10, y % 10, y / 10, 10, x % 10, x / 10};
        end else if (m_mode == 2) begin
            dv = '{z % 10, z / 10, 10, y % 10, y / 10, 10, x % 10, x / 10};
        end else if (m_mode == 3) begin
            dv = '{z % 10, z / 10, 10, y % 10, y / 10, 10, 11, 11};
        end else begin
            dv = '{z % 10, z / 10, 10, y % 10, y / 10, 10, x % 10, x / 10};
        end
        return dv[idx];
    endfunction

    task automatic check_outputs();
        logic [7:0] e_sel, e_led;
        logic [3:0] oh;
        e_sel = ~(8'd1 << m_scan);
        oh    = 4'b0001 << m_mode;
        e_led = {m_ring, m_tm_run, m_sw_run, m_al_en, oh};
        chk("seg_sel", seg_sel, e_sel);
        chk("seg_data", seg_data, code_of(model_digit(m_scan)));
        chk("led_1", led_1, e_led);
        chk("piezo", piezo, m_piezo);
        chk("led_r", led_r, {4{m_ring}});
        chk("led_g", led_g, {4{m_sw_run | m_tm_run}});
        chk("led_b", led_b, {4{m_al_en}});
        chk("lcd", {lcd_rs, lcd_rw, lcd_e, lcd_data}, 11'h000);
    endtask

    task automatic cycle();
        @(posedge clk_1k);
        model_step();
        @(negedge clk_1k);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        clr_sw = 1'b1;
        cycle();
        clr_sw = 1'b0;
    endtask

    task automatic press_btn(input int i);
        btn = 9'd1 << i;
        cycle();
        btn = '0;
        cycle();
    endtask

    task automatic load_digits(input logic [7:0] d7, d6, d5, d4, d3, d2, d1, d0);
        exp_q.delete();
        exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2); exp_q.push_back(d3);
        exp_q.push_back(d4); exp_q.push_back(d5); exp_q.push_back(d6); exp_q.push_back(d7);
    endtask

    task automatic check_digits(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            chk(tag, seg_data, exp_q[m_scan]);
        end
    endtask

    initial begin
        logic p;
        clr_sw = 1'b0; alarm_sw = 1'b0; stopwatch_sw = 1'b0; timer_sw = 1'b0; btn = '0;
        model_reset();

        // Reset values, then a held btn0 steps the hour exactly once.
        do_reset();
        chk("rst_seg_sel", seg_sel, 8'hFE);
        chk("rst_led_1", led_1, 8'h01);
        chk("rst_piezo", piezo, 1'b0);
        chk("rst_rgb", {led_r, led_g, led_b}, 12'h000);
        btn[0] = 1'b1;
        run(50);
        btn = '0;
        load_digits(8'h3F, 8'h06, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F);
        check_digits("hour_once", 8);

        // Timer start is blocked at 00:00.
        do_reset();
        timer_sw = 1'b1;
        run(2);
        btn[0] = 1'b1;
        run(50);
        btn = '0;
        cycle();
        chk("tm_blocked_run", led_1[6], 1'b0);
        chk("tm_mode_led", led_1[3], 1'b1);
        chk("tm_blocked_ring", led_1[7], 1'b0);

        // 3-second countdown, expiry ring, ring duration.
        repeat (3) press_btn(2);
        load_digits(8'h00, 8'h00, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h4F);
        check_digits("tm_set_0003", 8);
        press_btn(0);
        chk("tm_running", led_1[6], 1'b1);
        for (int i = 0; i < 4000 && !led_1[7]; i++) cycle();
        chk("tm_expire_ring", led_1[7], 1'b1);
        chk("tm_stopped", led_1[6], 1'b0);
        p = piezo;
        cycle();
        chk("piezo_toggle", piezo ^ p, 1'b1);
        run(9998);
        chk("ring_last_cycle", led_1[7], 1'b1);
        cycle();
        chk("ring_ended", led_1[7], 1'b0);
        chk("ring_ended_piezo", piezo, 1'b0);

        // Stopwatch: 1500 cycles of running is 1.50 s, then frozen, then cleared.
        timer_sw = 1'b0;
        stopwatch_sw = 1'b1;
        run(2);
        btn[0] = 1'b1;
        cycle();
        btn = '0;
        run(1499);
        btn[0] = 1'b1;
        cycle();
        btn = '0;
        load_digits(8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h06, 8'h40, 8'h6D, 8'h3F);
        check_digits("sw_frozen", 24);
        chk("sw_stopped", led_1[5], 1'b0);
        press_btn(1);
        load_digits(8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F);
        check_digits("sw_cleared", 8);

        // Alarm 00:01 enabled rings when the clock reaches 00:01:00.
        stopwatch_sw = 1'b0;
        do_reset();
        alarm_sw = 1'b1;
        run(2);
        press_btn(1);
        press_btn(2);
        alarm_sw = 1'b0;
        run(2);
        chk("al_enabled_led", led_1[4], 1'b1);
        chk("al_enabled_blue", led_b, 4'hF);
        for (int i = 0; i < 61000 && !led_1[7]; i++) cycle();
        chk("alarm_ring", led_1[7], 1'b1);
        btn[3] = 1'b1;
        cycle();
        btn = '0;
        cycle();
        chk("alarm_stop", led_1, 8'h11);

        // Random switches and buttons, including occasional resets.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                timer_sw     = ($urandom_range(0, 2) == 0);
                stopwatch_sw = ($urandom_range(0, 2) == 0);
                alarm_sw     = ($urandom_range(0, 2) == 0);
            end
            clr_sw = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0:       btn = '0;
                1, 2:    btn = 9'd1 << $urandom_range(0, 4);
                default: btn = 9'($urandom_range(0, 511));
            endcase
            repeat ($urandom_range(1, 3)) cycle();
            clr_sw = 1'b0;
        end

        // Reset in the middle of operation overrides everything.
        btn = '0; timer_sw = 1'b0; stopwatch_sw = 1'b0; alarm_sw = 1'b0;
        run(3);
        btn[0] = 1'b1;
        cycle();
        btn = '0;
        clr_sw = 1'b1;
        cycle();
        clr_sw = 1'b0;
        chk("mid_rst_seg_sel", seg_sel, 8'hFE);
        chk("mid_rst_led_1", led_1, 8'h01);
        chk("mid_rst_piezo", piezo, 1'b0);
        chk("mid_rst_rgb", {led_r, led_g, led_b}, 12'h000);
        load_digits(8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F);
        check_digits("mid_rst_time", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digital_clock.md
Name: digital_clock

Overview:
- Top-level 24-hour digital clock running on a 1 kHz system clock.
- Provides four modes: clock, alarm-set, stopwatch and countdown timer.
- Buttons pass through per-bit one-shot detection, so holding a button performs exactly one action.
- Drives an 8-digit multiplexed 7-segment display, a piezo, and status LEDs. The LCD port is reserved in this revision.

Parameters:
- CLK_HZ, 1000, clock cycles per second (second-tick prescale).
- CS_DIV, 10, clock cycles per stopwatch centisecond.
- RING_SEC, 10, buzzer duration in seconds.

Ports:
- clk_1k  in  1  system clock, 1 kHz.
- clr_sw  in  1  synchronous active-high reset.
- alarm_sw  in  1  alarm-set mode select.
- stopwatch_sw  in  1  stopwatch mode select.
- timer_sw  in  1  timer mode select.
- btn  in  9  push buttons, active-high.
- seg_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- seg_sel  out  8  digit select, one-hot active-low; bit 7 is the leftmost digit.
- lcd_rs, lcd_rw, lcd_e  out  1 each  reserved, constant 0.
- lcd_data  out  8  reserved, constant 8'h00.
- piezo  out  1  buzzer drive.
- led_1  out  8  status LEDs.
- led_r, led_g, led_b  out  4 each  RGB status.

Behaviour:
- Reset (clr_sw=1 at a clk_1k edge) clears all of the following:
  - time to 00:00:00 and prescalers to 0;
  - alarm to 00:00, disabled;
  - stopwatch to 00:00.00, stopped;
  - timer to 00:00, stopped;
  - ring off, scan index 0.
- Output reset values: piezo=0, seg_sel=8'hFE, led_1=8'h01, RGB all 0.
- One-shot: btn_d <= btn each cycle; press[i] = btn[i] & ~btn_d[i], a single-cycle pulse. btn_d resets to 0.
- Mode priority: timer_sw > stopwatch_sw > alarm_sw > clock.
- Timekeeping and the running stopwatch/timer continue in every mode. Buttons act only on the current mode.
- Second tick: asserted once every CLK_HZ cycles.
- Time counts seconds 0..59, minutes 0..59, hours 0..23; 23:59:59 wraps to 00:00:00.
- Clock mode buttons:
  - btn0: hour+1, wrapping 23->0.
  - btn1: minute+1, wrapping 59->0 with no carry.
  - btn2: seconds and prescaler cleared to 0.
- Alarm mode buttons:
  - btn0: alarm hour+1.
  - btn1: alarm minute+1.
  - btn2: toggle alarm enable.
- Stopwatch mode buttons:
  - btn0: start/stop.
  - btn1: clear to 0, honoured only while stopped.
- Stopwatch counting: centisecond+1 every CS_DIV cycles while running. Centiseconds 0..99, seconds 0..59, minutes 0..59; 59:59.99 wraps to 0.
- Timer mode buttons:
  - btn0: start/stop.
  - btn1: minute+1 (wraps 59->0), honoured only while stopped.
  - btn2: second+1 (wraps 59->0), honoured only while stopped.
  - btn3: clear, honoured only while stopped.
- Timer start block: btn0 start is ignored while the timer value is 00:00.
- Timer countdown: decrements once per second tick while running. On reaching 00:00 the timer stops and ring starts.
- btn4..btn8 have no function.
- Ring start conditions:
  - alarm enabled and a second tick lands time on AH:AM:00; or
  - timer expiry.
- Ring lasts RING_SEC second ticks.
- Any press while ringing stops the ring. That press performs no other action.
- piezo toggles every cycle while ringing and is 0 otherwise.
- Simultaneous presses: handle the lowest index only.
- Display scan: the index increments each cycle, 0..7 wrapping. seg_sel = ~(1<<idx). seg_data is decoded combinationally for digit idx.
- Digit codes: 0-9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; '-' = 40; blank = 00; dp = bit 7.
- Digits 7..0 per mode:
  - Clock: H1 H0 - M1 M0 - S1 S0.
  - Alarm: AH1 AH0 - AM1 AM0 - blank E, where E = 1 if enabled, else 0.
  - Stopwatch: M1 M0 - S1 S0 - C1 C0.
  - Timer: blank blank - M1 M0 - S1 S0.
- led_1 bits:
  - [3:0]: one-hot mode (clock, alarm, stopwatch, timer);
  - [4]: alarm enabled;
  - [5]: stopwatch running;
  - [6]: timer running;
  - [7]: ringing.
- RGB: led_r = {4{ringing}}, led_g = {4{stopwatch or timer running}}, led_b = {4{alarm enabled}}.
- Mid-operation reset overrides everything in the same cycle.
- Mode switch changes affect the display and button routing the next cycle. Counters are unaffected.

Test Plan:
- Reset, then hold btn0 for 50 cycles in clock mode -> hour goes 00->01 exactly once. Display scan shows digit7=3F, digit6=06.
- After reset, timer_sw=1, hold btn0 for 50 cycles -> timer stays stopped (blocked at 00:00). led_1[6]=0, led_1[3]=1, no ring.
- Timer mode: btn2 ×3 giving 00:03, then btn0 -> counts down over 3000 cycles to 00:00. Then ringing: led_1[7]=1, piezo toggling, ring stops after 10000 cycles.
- Stopwatch mode: btn0, wait 1500 cycles, btn0 -> display 00-01-50 and frozen; btn1 -> 00-00-00.
- Alarm set to 00:01 and enabled with btn2, then clock mode; after 60000 cycles -> ring starts. A btn3 press stops the ring with no other effect.
- Press btn0 then assert clr_sw for 1 cycle -> all state back to reset values, seg_sel=FE on the next cycle.
